// File: rtl/dm_bus_arbiter.sv
// Two-master arbiter for the shared data-memory/IO bus.
// Registered grant FSM with a round-robin tie-break and a bounded hold time. The slave side is a
// combinational mux driven only from registered state, so grants are never combinational.
module dm_bus_arbiter #(
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_rd,
   input  logic          m0_wr,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   input  logic          m1_req,
   input  logic          m1_rd,
   input  logic          m1_wr,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic [DW-1:0] rdata,
   output logic          dm_cs,
   output logic          dm_rd,
   output logic          dm_wr,
   output logic [AW-1:0] dm_address,
   output logic [DW-1:0] dm_d_in,
   input  logic [DW-1:0] dm_out
);

   localparam int unsigned HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HoldMax = HW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

   state_e        state_q, state_d;
   logic          last_q, last_d;
   logic [HW-1:0] hcnt_q, hcnt_d;

   // Grant FSM: pick the next owner, then derive last-served pointer and hold counter.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      hcnt_d  = hcnt_q;
      case (state_q)
         StIdle: begin
            // On a tie the master that was not served last wins.
            if (m0_req && m1_req) state_d = last_q ? StOwn0 : StOwn1;
            else if (m0_req)      state_d = StOwn0;
            else if (m1_req)      state_d = StOwn1;
         end
         StOwn0: begin
            if (!m0_req)                          state_d = m1_req ? StOwn1 : StIdle;
            else if (m1_req && hcnt_q == HoldMax) state_d = StOwn1;
         end
         StOwn1: begin
            if (!m1_req)                          state_d = m0_req ? StOwn0 : StIdle;
            else if (m0_req && hcnt_q == HoldMax) state_d = StOwn0;
         end
         default: state_d = StIdle;
      endcase

      if (state_d != state_q) begin
         if (state_d == StOwn0) begin
            last_d = 1'b0;
            hcnt_d = '0;
         end else if (state_d == StOwn1) begin
            last_d = 1'b1;
            hcnt_d = '0;
         end
      end else if (state_q != StIdle && hcnt_q != HoldMax) begin
         // Saturate so an uncontested owner never wraps the counter.
         hcnt_d = hcnt_q + 1'b1;
      end
   end

   // State registers; last resets to 1 so master 0 wins the first tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         last_q  <= 1'b1;
         hcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         hcnt_q  <= hcnt_d;
      end
   end

   // Slave-side mux from registered owner; everything is 0 in IDLE (and hence during reset).
   always_comb begin
      m0_gnt     = 1'b0;
      m1_gnt     = 1'b0;
      dm_rd      = 1'b0;
      dm_wr      = 1'b0;
      dm_address = '0;
      dm_d_in    = '0;
      case (state_q)
         StOwn0: begin
            m0_gnt     = 1'b1;
            dm_wr      = m0_wr;
            dm_rd      = m0_rd & ~m0_wr;  // rd+wr together counts as a write
            dm_address = m0_addr;
            dm_d_in    = m0_wdata;
         end
         StOwn1: begin
            m1_gnt     = 1'b1;
            dm_wr      = m1_wr;
            dm_rd      = m1_rd & ~m1_wr;
            dm_address = m1_addr;
            dm_d_in    = m1_wdata;
         end
         default: ;
      endcase
      dm_cs = dm_rd | dm_wr;
      rdata = dm_out;
   end

endmodule
